hdr_stream_arbiter: RTL and testbench
=====================================

Name: hdr_stream_arbiter

Overview:
- Packet-level round-robin arbiter that shares one header-insertion datapath (DATA_WIDTH stream plus HEADER_SIZE header) among NUM_SRC packet sources.
- Each source has its own header word. The block selects a source at a packet boundary and locks the grant until that packet's eop is accepted.
- During the packet it forwards the source's beats and holds the source's header, captured at grant time, stable on hdr_out.
- It sits directly upstream of the header adder; the adder's data_in_* ports and header_data port connect to out_* and hdr_out.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16).
- DATA_WIDTH, 128, stream data width in bits (multiple of 8).
- HEADER_SIZE, 256, header width in bits (multiple of DATA_WIDTH).

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- src_enable  in  NUM_SRC  per-source arbitration enable
- src_header  in  NUM_SRC*HEADER_SIZE  per-source header; source i occupies bits [(i+1)*HEADER_SIZE-1 : i*HEADER_SIZE]
- in_data  in  NUM_SRC*DATA_WIDTH  per-source data, packed the same way
- in_valid  in  NUM_SRC  per-source valid
- in_sop  in  NUM_SRC  per-source start of packet
- in_eop  in  NUM_SRC  per-source end of packet
- in_empty  in  NUM_SRC*$clog2(DATA_WIDTH/8)  per-source empty byte count on the eop beat
- in_ready  out  NUM_SRC  per-source ready
- out_data  out  DATA_WIDTH  granted source data
- out_valid  out  1  output valid
- out_sop  out  1  output start of packet
- out_eop  out  1  output end of packet
- out_empty  out  $clog2(DATA_WIDTH/8)  output empty
- out_ready  in  1  downstream ready
- hdr_out  out  HEADER_SIZE  header for the current packet
- grant_id  out  $clog2(NUM_SRC)  index of the granted source
- busy  out  1  a packet is in flight
- sop_err  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset values (asynchronous):
  - State IDLE; grant_id 0; rr_ptr 0; hdr_out 0.
  - busy 0, sop_err 0, out_valid 0, in_ready all 0.
- State machine states: IDLE and BUSY.
- IDLE:
  - Requester set = in_valid & src_enable.
  - If the set is non-empty, the winner is the first requester found scanning from rr_ptr upward, wrapping modulo NUM_SRC.
  - On the next edge: grant_id <= winner; hdr_out <= src_header[winner]; state <= BUSY.
  - If the winner's current beat has in_sop=0, sop_err pulses high for one cycle in that same cycle. The packet is still granted.
- IDLE outputs: out_valid=0; in_ready all 0. No beat is transferred in IDLE, so arbitration costs exactly 1 cycle.
- BUSY outputs (combinational pass-through from source g=grant_id):
  - out_valid = in_valid[g]; out_data, out_sop, out_eop = source g's fields.
  - out_empty = in_empty[g] when in_eop[g], else 0.
  - in_ready[g] = out_ready; in_ready for every other source = 0.
  - busy=1.
- BUSY transitions:
  - Beat accepted = in_valid[g] & out_ready.
  - An accepted beat with in_eop[g] moves to IDLE and sets rr_ptr <= (g+1) mod NUM_SRC.
  - An accepted beat with in_sop[g] that is not the first beat of the packet pulses sop_err; the beat is still forwarded.
- hdr_out is held constant from grant until the eop beat is accepted. Changes on src_header mid-packet have no effect until the next grant.
- Clearing src_enable[g] mid-packet does not abort the packet. It only excludes source g from later arbitration.
- A single-beat packet (sop and eop on one beat) completes in one BUSY cycle.
- Back-to-back packets from any sources see a 1-cycle IDLE gap between them.
- Fairness:
  - After serving source g, source g has the lowest priority in the next arbitration.
  - With all sources continuously requesting, the grant order is 0, 1, …, NUM_SRC-1, 0, …
- No requester in IDLE: stay in IDLE, rr_ptr unchanged.
- Reset asserted mid-packet: immediate return to reset values. No partial-packet recovery; the upstream must restart from sop.
- Downstream backpressure (out_ready=0) stalls only the granted source. The grant never changes while in BUSY.

Test Plan:
- Reset, then only source 2 sends a 3-beat packet (sop on beat 0, eop with empty=5 on beat 2) -> grant_id=2 one cycle after valid; hdr_out=src_header[2]; 3 beats out in order with out_empty=5 on the last beat; busy falls after eop; rr_ptr=3.
- All 4 sources continuously send 1-beat packets -> grants in order 0,1,2,3,0; each packet is followed by a 1-cycle IDLE gap; non-granted in_ready stay 0.
- Source 1 packet with out_ready toggled 0/1 each cycle and src_header[1] changed mid-packet -> data is held while stalled, no beat is lost or duplicated, and hdr_out keeps the value captured at grant.
- src_enable=4'b1011 with all sources valid -> source 2 is never granted; clearing src_enable[0] during source 0's packet still lets that packet complete.
- Source 3 is granted on a beat with in_sop=0, and a mid-packet beat carries in_sop=1 -> sop_err pulses exactly once in each case, and the packet is forwarded intact.
- Reset asserted during beat 2 of a 4-beat packet -> out_valid=0, in_ready=0, busy=0 and grant_id=0 immediately; a new packet from source 1 afterwards is granted normally.

Source files
------------

// File: rtl/hdr_stream_arbiter.sv
// Packet-level round-robin arbiter feeding one header-insertion datapath.
// A grant is locked from selection until the granted source's eop beat is accepted.
module hdr_stream_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int DATA_WIDTH  = 128,
    parameter int HEADER_SIZE = 256
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_SRC-1:0]                     src_enable,
    input  logic [NUM_SRC*HEADER_SIZE-1:0]         src_header,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]          in_data,
    input  logic [NUM_SRC-1:0]                     in_valid,
    input  logic [NUM_SRC-1:0]                     in_sop,
    input  logic [NUM_SRC-1:0]                     in_eop,
    input  logic [NUM_SRC*$clog2(DATA_WIDTH/8)-1:0] in_empty,
    output logic [NUM_SRC-1:0]                     in_ready,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic                                   out_valid,
    output logic                                   out_sop,
    output logic                                   out_eop,
    output logic [$clog2(DATA_WIDTH/8)-1:0]        out_empty,
    input  logic                                   out_ready,
    output logic [HEADER_SIZE-1:0]                 hdr_out,
    output logic [$clog2(NUM_SRC)-1:0]             grant_id,
    output logic                                   busy,
    output logic                                   sop_err
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int EW = $clog2(DATA_WIDTH/8);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_nxt;

    logic [GW-1:0] rr_ptr, rr_nxt;
    logic [GW-1:0] grant_nxt;
    logic [GW-1:0] winner, idx;
    logic          found;
    logic          first_beat, first_nxt;
    logic          load_hdr;
    logic          err;
    logic [NUM_SRC-1:0] req;

    logic [DATA_WIDTH-1:0]  data_a  [NUM_SRC];
    logic [HEADER_SIZE-1:0] hdr_a   [NUM_SRC];
    logic [EW-1:0]          empty_a [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign data_a[i]  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign hdr_a[i]   = src_header[i*HEADER_SIZE +: HEADER_SIZE];
        assign empty_a[i] = in_empty[i*EW +: EW];
    end

    assign req = in_valid & src_enable;

    // Scan upward from rr_ptr so the most recently served source is checked last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = GW'((int'(rr_ptr) + k) % NUM_SRC);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        rr_nxt    = rr_ptr;
        first_nxt = first_beat;
        load_hdr  = 1'b0;
        err       = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_empty = '0;
        in_ready  = '0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    grant_nxt = winner;
                    load_hdr  = 1'b1;
                    first_nxt = 1'b1;
                    err       = ~in_sop[winner];
                end
            end
            BUSY: begin
                busy               = 1'b1;
                out_valid          = in_valid[grant_id];
                out_data           = data_a[grant_id];
                out_sop            = in_sop[grant_id];
                out_eop            = in_eop[grant_id];
                out_empty          = in_eop[grant_id] ? empty_a[grant_id] : '0;
                in_ready[grant_id] = out_ready;
                if (in_valid[grant_id] && out_ready) begin
                    first_nxt = 1'b0;
                    // The first beat's sop was already judged at grant time.
                    if (in_sop[grant_id] && !first_beat)
                        err = 1'b1;
                    if (in_eop[grant_id]) begin
                        state_nxt = IDLE;
                        rr_nxt    = (grant_id == GW'(NUM_SRC-1)) ? '0 : grant_id + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sop_err = err & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            rr_ptr     <= '0;
            first_beat <= 1'b0;
            hdr_out    <= '0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            rr_ptr     <= rr_nxt;
            first_beat <= first_nxt;
            if (load_hdr)
                hdr_out <= hdr_a[winner];
        end
    end

endmodule

// File: tb/tb_hdr_stream_arbiter.sv
// Scoreboard bench for hdr_stream_arbiter: a packet-level round-robin model
// predicts the output beat stream; a negedge monitor consumes it.
module tb_hdr_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int HW = 256;
    localparam int EW = 4;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_enable;
    logic [N*HW-1:0] src_header;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid, in_sop, in_eop;
    logic [N*EW-1:0] in_empty;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid, out_sop, out_eop;
    logic [EW-1:0]   out_empty;
    logic            out_ready;
    logic [HW-1:0]   hdr_out;
    logic [GW-1:0]   grant_id;
    logic            busy, sop_err;

    hdr_stream_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .HEADER_SIZE(HW)) dut (
        .clk(clk), .rst(rst), .src_enable(src_enable), .src_header(src_header),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_empty(in_empty), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_empty(out_empty), .out_ready(out_ready), .hdr_out(hdr_out),
        .grant_id(grant_id), .busy(busy), .sop_err(sop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [HW-1:0] hdr;
        logic [GW-1:0] gid;
    } exp_t;

    beat_t         srcq [N][$];
    logic [HW-1:0] hdrq [N][$];
    logic          firstb [N];
    exp_t          exp_q [$];

    int   rd_idx   = 0;
    int   err_seen = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_ptr    = 0;
    int   exp_err  = 0;
    int   bp_mode  = 0;
    logic clr_en0  = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [HW-1:0] rand_hdr();
        logic [HW-1:0] r;
        for (int k = 0; k < HW/32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic add_pkt(input int s, input int len, input bit bad_first,
                           input bit mid_sop, input int last_empty);
        beat_t b;
        hdrq[s].push_back(rand_hdr());
        for (int k = 0; k < len; k++) begin
            b.data  = rand_data();
            b.sop   = (k == 0) ? !bad_first : (mid_sop && k == 1);
            b.eop   = (k == len-1);
            b.empty = EW'($urandom_range(0, 15));
            if (b.eop && last_empty >= 0) b.empty = EW'(last_empty);
            srcq[s].push_back(b);
        end
    endtask

    // Whole packets in round-robin order over sources holding pending packets.
    task automatic run_model(input logic [N-1:0] mask);
        beat_t         q  [N][$];
        logic [HW-1:0] hq [N][$];
        beat_t         b;
        exp_t          e;
        logic [HW-1:0] h;
        int            s, k;
        bit            any;
        for (int i = 0; i < N; i++) begin
            q[i]  = srcq[i];
            hq[i] = hdrq[i];
        end
        while (1) begin
            any = 0;
            s   = 0;
            for (int j = 0; j < N; j++) begin
                int c;
                c = (m_ptr + j) % N;
                if (!any && mask[c] && q[c].size() > 0) begin
                    any = 1;
                    s   = c;
                end
            end
            if (!any) break;
            h = hq[s].pop_front();
            k = 0;
            while (1) begin
                b       = q[s].pop_front();
                e.data  = b.data;
                e.sop   = b.sop;
                e.eop   = b.eop;
                e.empty = b.eop ? b.empty : '0;
                e.hdr   = h;
                e.gid   = GW'(s);
                exp_q.push_back(e);
                if ((k == 0 && !b.sop) || (k > 0 && b.sop)) exp_err++;
                k++;
                if (b.eop) break;
            end
            m_ptr = (s + 1) % N;
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                b = srcq[i][0];
                in_valid[i]            = 1'b1;
                in_data[i*DW +: DW]    = b.data;
                in_sop[i]              = b.sop;
                in_eop[i]              = b.eop;
                in_empty[i*EW +: EW]   = b.empty;
                if (firstb[i]) begin
                    if (hdrq[i].size() > 0) src_header[i*HW +: HW] = hdrq[i][0];
                end else begin
                    src_header[i*HW +: HW] = rand_hdr();
                end
            end else begin
                in_valid[i] = 1'b0;
                in_sop[i]   = 1'b0;
                in_eop[i]   = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0]  acc;
        beat_t         b;
        logic [HW-1:0] hd;
        @(negedge clk);
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && srcq[i].size() > 0) begin
                b = srcq[i].pop_front();
                if (b.eop) begin
                    firstb[i] = 1'b1;
                    if (hdrq[i].size() > 0) hd = hdrq[i].pop_front();
                end else begin
                    firstb[i] = 1'b0;
                end
                if (clr_en0 && i == 0) src_enable[0] = 1'b0;
            end
        end
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 9) < 7);
        endcase
        drive();
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            hdrq[i].delete();
            firstb[i] = 1'b1;
        end
        drive();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        flush();
        repeat (2) @(posedge clk);
        #2;
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    task automatic run_phase(input logic [N-1:0] mask);
        int cyc, base_err;
        bit done;
        exp_err  = 0;
        base_err = err_seen;
        run_model(mask);
        cyc = 0;
        while (1) begin
            step();
            cyc++;
            done = (rd_idx == exp_q.size());
            for (int i = 0; i < N; i++)
                if (mask[i] && srcq[i].size() > 0) done = 0;
            if (done) break;
            if (cyc > 3000) begin
                chk("phase_timeout", 1, 0);
                break;
            end
        end
        step();
        step();
        chk("sop_err_count", err_seen - base_err, exp_err);
    endtask

    // Monitor: consumes expectations whenever a beat is accepted downstream.
    initial begin
        exp_t e;
        bit   gap, lat;
        gap = 0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gap    = 0;
                lat    = 0;
                rd_idx = exp_q.size();
                continue;
            end
            if (lat) chk("arb_latency", busy, 1);
            lat = 0;
            if (gap) chk("idle_gap", {out_valid, busy}, 0);
            gap = 0;
            if (sop_err) err_seen++;
            if (!busy && |(in_valid & src_enable)) lat = 1;
            if (out_valid && out_ready) begin
                if (rd_idx >= exp_q.size()) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q[rd_idx];
                    rd_idx++;
                    chk("beat",
                        {out_data, out_sop, out_eop, out_empty, hdr_out, grant_id, in_ready, busy},
                        {e.data, e.sop, e.eop, e.empty, e.hdr, e.gid, 4'(4'd1 << e.gid), 1'b1});
                    if (e.eop) gap = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cyc;
        rst        = 1'b1;
        src_enable = '1;
        src_header = '0;
        in_data    = '0;
        in_valid   = '0;
        in_sop     = '0;
        in_eop     = '0;
        in_empty   = '0;
        out_ready  = 1'b1;
        for (int i = 0; i < N; i++) firstb[i] = 1'b1;

        // Reset holds everything quiet even with a malformed request pending.
        repeat (2) @(posedge clk);
        #1;
        in_valid = 4'b0100;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sop_err", sop_err, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_hdr_out", hdr_out, 0);
        in_valid = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;

        add_pkt(2, 3, 0, 0, 5);
        run_phase(4'hF);
        // rr_ptr now points past source 2, so source 3 beats source 0.
        add_pkt(0, 1, 0, 0, -1);
        add_pkt(3, 1, 0, 0, -1);
        run_phase(4'hF);

        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) add_pkt(s, 1, 0, 0, -1);
        run_phase(4'hF);

        bp_mode = 1;
        add_pkt(1, 6, 0, 0, -1);
        run_phase(4'hF);
        bp_mode = 0;

        do_reset();
        src_enable = 4'b1011;
        clr_en0    = 1'b1;
        add_pkt(0, 2, 0, 0, -1);
        for (int r = 0; r < 2; r++) begin
            add_pkt(1, 2, 0, 0, -1);
            add_pkt(2, 2, 0, 0, -1);
            add_pkt(3, 3, 0, 0, -1);
        end
        run_phase(4'b1011);
        clr_en0 = 1'b0;
        flush();
        src_enable = '1;

        add_pkt(3, 3, 1, 0, -1);
        add_pkt(3, 4, 0, 1, -1);
        run_phase(4'hF);

        do_reset();
        add_pkt(0, 4, 0, 0, -1);
        exp_err = 0;
        run_model(4'hF);
        base = rd_idx;
        cyc  = 0;
        while (rd_idx - base < 2 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("pre_reset_beats", rd_idx - base, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant_id", grant_id, 0);
        chk("mid_rst_hdr_out", hdr_out, 0);
        flush();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        m_ptr = 0;
        add_pkt(1, 3, 0, 0, -1);
        run_phase(4'hF);

        bp_mode = 2;
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < N; s++) add_pkt(s, $urandom_range(1, 4), 0, 0, -1);
        run_phase(4'hF);
        bp_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
